framebuffer_reader: RTL and testbench
=====================================

FRAMEBUFFER_READER -- requirements
Module: FramebufferReader

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, AXI data width; ADDR_WIDTH, default 32, address width; ID_WIDTH, default 8, AXI ID width; X_BIT_WIDTH, default 11, max X width; Y_BIT_WIDTH, default 11, max Y width; PIXEL_WIDTH, default 16, pixel width; derived PPB = DATA_WIDTH/PIXEL_WIDTH pixels per beat, STRB_WIDTH = DATA_WIDTH/8.
REQ-002 Ports SHALL be, in order: aclk in 1 clock; resetn in 1 reset (one clock; reset is synchronous and active-low).
REQ-003 start in 1 single-cycle request to read one frame; busy out 1 frame in progress; error out 1 sticky read-error flag.
REQ-004 confAddr in ADDR_WIDTH frame base byte address; confXResolution in X_BIT_WIDTH; confYResolution in Y_BIT_WIDTH.
REQ-005 m_frag_tvalid out 1; m_frag_tready in 1; m_frag_tdata out PIXEL_WIDTH; m_frag_tlast out 1 last pixel of frame; m_frag_txpos out X_BIT_WIDTH; m_frag_typos out Y_BIT_WIDTH.
REQ-006 m_mem_axi_arid out ID_WIDTH; arid, araddr (ADDR_WIDTH), arlen (8), arsize (3), arburst (2), arlock (1), arcache (4), arprot (3), arvalid (1) outputs; arready in 1.
REQ-007 m_mem_axi_rid in ID_WIDTH; rdata in DATA_WIDTH; rresp in 2; rlast in 1; rvalid in 1; rready out 1.

Function
REQ-008 Constants: arlen SHALL be 0 (single beat), arsize = log2(STRB_WIDTH), arburst = 1, arlock/arcache/arprot = 0.
REQ-009 start SHALL be accepted only when busy=0; config inputs SHALL be sampled on the accept cycle; start while busy SHALL be ignored.
REQ-010 Accepted start with X=0 or Y=0 SHALL leave busy=0 and issue no transaction.
REQ-011 Otherwise busy SHALL be 1 from the next cycle; total = X*Y pixels; beats = ceil(total/PPB).
REQ-012 Beat k SHALL be requested at araddr = confAddr + k*STRB_WIDTH, k = 0..beats-1, in order; arid SHALL increment by 1 per request (wrapping).
REQ-013 At most one AR SHALL be outstanding; beat 0 AR SHALL assert the cycle after start acceptance; AR k+1 SHALL assert the cycle after beat k is accepted on R, if k+1 < beats.
REQ-014 arvalid SHALL stay high with stable araddr/arid until arready; deassert the cycle after the handshake.
REQ-015 One beat buffer: rready SHALL be 1 exactly when the buffer is empty and busy=1; an R handshake fills the buffer.
REQ-016 Buffered beat SHALL be emitted as pixels LSB first: pixel i = rdata[i*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-017 m_frag_tvalid SHALL assert the cycle after the buffer fills; pixel advance only on tvalid&&tready; tdata/txpos/typos/tlast stable while tvalid&&!tready.
REQ-018 Buffer SHALL become empty in the cycle its last valid pixel handshakes; rready may rise the next cycle.
REQ-019 txpos SHALL count 0..X-1, wrapping to 0 and incrementing typos; typos 0..Y-1.
REQ-020 In a final partial beat, pixels with index >= total SHALL be discarded, never output.
REQ-021 m_frag_tlast SHALL be 1 only on pixel (X-1, Y-1); its handshake SHALL clear busy the next cycle; a start the same cycle as busy falls SHALL be ignored.
REQ-022 rresp != 0 on an R handshake SHALL set error; data SHALL still be emitted; error SHALL clear only on reset or accepted start.
REQ-023 rid and rlast SHALL be ignored.
REQ-024 Throughput: no more than one pixel per cycle.

Reset
REQ-025 While resetn=0 at a clock edge: busy=0, error=0, arvalid=0, arid=0, rready=0, m_frag_tvalid=0, m_frag_tlast=0, txpos=0, typos=0, buffer empty.
REQ-026 Reset mid-frame SHALL abandon the frame and any outstanding AR; R beats arriving after reset release while busy=0 SHALL not be accepted (rready=0).

Verification
REQ-027 X=4, Y=2, confAddr=0x1000, arready/tready always 1 -> ARs at 0x1000,0x1004,0x1008,0x100C, arid 1..4; 8 pixels (0,0)..(3,1); tlast only on 8th; busy falls after.
REQ-028 X=3, Y=1 -> 2 beats; beat 1 emits only pixel rdata[15:0]; upper half discarded; tlast on (2,0).
REQ-029 tready toggled 1/0 each cycle, arready delayed 3 cycles -> araddr/arid stable while waiting; output pixel order and values identical to REQ-027 stimulus.
REQ-030 rresp=2 on beat 1 of X=4,Y=1 -> error=1 from next cycle, all 4 pixels still output; next start clears error.
REQ-031 start with X=0, Y=5 -> no arvalid, busy stays 0; start pulse during busy -> no effect on address sequence.
REQ-032 resetn low for 1 cycle after beat 0 accepted -> all outputs at REQ-025 values; a fresh start reissues from confAddr with arid=1.

Source files
------------

// File: rtl/framebuffer_reader_if.sv
// framebuffer_reader_if: AXI read channels toward memory plus the outgoing pixel stream.
interface framebuffer_reader_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 8,
  parameter int X_BIT_WIDTH = 11,
  parameter int Y_BIT_WIDTH = 11,
  parameter int PIXEL_WIDTH = 16
);
  logic                   m_frag_tvalid;
  logic                   m_frag_tready;
  logic [PIXEL_WIDTH-1:0] m_frag_tdata;
  logic                   m_frag_tlast;
  logic [X_BIT_WIDTH-1:0] m_frag_txpos;
  logic [Y_BIT_WIDTH-1:0] m_frag_typos;
  logic [ID_WIDTH-1:0]    m_mem_axi_arid;
  logic [ADDR_WIDTH-1:0]  m_mem_axi_araddr;
  logic [7:0]             m_mem_axi_arlen;
  logic [2:0]             m_mem_axi_arsize;
  logic [1:0]             m_mem_axi_arburst;
  logic                   m_mem_axi_arlock;
  logic [3:0]             m_mem_axi_arcache;
  logic [2:0]             m_mem_axi_arprot;
  logic                   m_mem_axi_arvalid;
  logic                   m_mem_axi_arready;
  logic [ID_WIDTH-1:0]    m_mem_axi_rid;
  logic [DATA_WIDTH-1:0]  m_mem_axi_rdata;
  logic [1:0]             m_mem_axi_rresp;
  logic                   m_mem_axi_rlast;
  logic                   m_mem_axi_rvalid;
  logic                   m_mem_axi_rready;
  modport master (
    output m_frag_tvalid, m_frag_tdata, m_frag_tlast, m_frag_txpos, m_frag_typos,
    input  m_frag_tready,
    output m_mem_axi_arid, m_mem_axi_araddr, m_mem_axi_arlen, m_mem_axi_arsize, m_mem_axi_arburst,
    output m_mem_axi_arlock, m_mem_axi_arcache, m_mem_axi_arprot, m_mem_axi_arvalid,
    input  m_mem_axi_arready,
    input  m_mem_axi_rid, m_mem_axi_rdata, m_mem_axi_rresp, m_mem_axi_rlast, m_mem_axi_rvalid,
    output m_mem_axi_rready
  );
  modport slave (
    input  m_frag_tvalid, m_frag_tdata, m_frag_tlast, m_frag_txpos, m_frag_typos,
    output m_frag_tready,
    input  m_mem_axi_arid, m_mem_axi_araddr, m_mem_axi_arlen, m_mem_axi_arsize, m_mem_axi_arburst,
    input  m_mem_axi_arlock, m_mem_axi_arcache, m_mem_axi_arprot, m_mem_axi_arvalid,
    output m_mem_axi_arready,
    output m_mem_axi_rid, m_mem_axi_rdata, m_mem_axi_rresp, m_mem_axi_rlast, m_mem_axi_rvalid,
    input  m_mem_axi_rready
  );
endinterface

// File: rtl/framebuffer_reader.sv
// framebuffer_reader: fetches a frame one AXI beat at a time and streams it out pixel by pixel.
module framebuffer_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 8,
  parameter int X_BIT_WIDTH = 11,
  parameter int Y_BIT_WIDTH = 11,
  parameter int PIXEL_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic                   start,
  output logic                   busy,
  output logic                   error,
  input  logic [ADDR_WIDTH-1:0]  conf_addr,
  input  logic [X_BIT_WIDTH-1:0] conf_x_resolution,
  input  logic [Y_BIT_WIDTH-1:0] conf_y_resolution,
  framebuffer_reader_if.master   bus
);
  localparam int PPB        = DATA_WIDTH / PIXEL_WIDTH;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int TW         = X_BIT_WIDTH + Y_BIT_WIDTH + 1;
  localparam int SW         = PPB > 1 ? $clog2(PPB) : 1;
  logic [TW-1:0]          total, beats, beats_left;
  logic [X_BIT_WIDTH-1:0] x_res, x_pos;
  logic [Y_BIT_WIDTH-1:0] y_res, y_pos;
  logic [SW-1:0]          sub;
  logic [DATA_WIDTH-1:0]  beat_buf;
  logic [ADDR_WIDTH-1:0]  ar_addr;
  logic [ID_WIDTH-1:0]    ar_id;
  logic                   ar_valid, f_valid;
  logic                   accept, zero, r_hs, f_hs, x_last, last_pix, unused_ok;
  assign accept   = start && !busy;
  assign zero     = conf_x_resolution == '0 || conf_y_resolution == '0;
  assign total    = TW'(conf_x_resolution) * TW'(conf_y_resolution);
  assign beats    = (total + TW'(PPB - 1)) / TW'(PPB);
  assign r_hs     = bus.m_mem_axi_rvalid && bus.m_mem_axi_rready;
  assign f_hs     = f_valid && bus.m_frag_tready;
  assign x_last   = x_pos == x_res - X_BIT_WIDTH'(1);
  assign last_pix = x_last && y_pos == y_res - Y_BIT_WIDTH'(1);
  assign bus.m_frag_tvalid     = f_valid;
  assign bus.m_frag_tdata      = beat_buf[PIXEL_WIDTH-1:0];
  assign bus.m_frag_tlast      = f_valid && last_pix;
  assign bus.m_frag_txpos      = x_pos;
  assign bus.m_frag_typos      = y_pos;
  assign bus.m_mem_axi_arid    = ar_id;
  assign bus.m_mem_axi_araddr  = ar_addr;
  assign bus.m_mem_axi_arlen   = 8'd0;
  assign bus.m_mem_axi_arsize  = 3'($clog2(STRB_WIDTH));
  assign bus.m_mem_axi_arburst = 2'b01;
  assign bus.m_mem_axi_arlock  = 1'b0;
  assign bus.m_mem_axi_arcache = 4'd0;
  assign bus.m_mem_axi_arprot  = 3'd0;
  assign bus.m_mem_axi_arvalid = ar_valid;
  assign bus.m_mem_axi_rready  = busy && !f_valid;
  assign unused_ok = ^{bus.m_mem_axi_rid, bus.m_mem_axi_rlast};
  // The buffer shifts right per pixel so tdata is always its low slice; pixels past the frame end are dropped when busy falls.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      busy       <= 1'b0;
      error      <= 1'b0;
      ar_valid   <= 1'b0;
      ar_addr    <= '0;
      ar_id      <= '0;
      f_valid    <= 1'b0;
      x_pos      <= '0;
      y_pos      <= '0;
      x_res      <= '0;
      y_res      <= '0;
      sub        <= '0;
      beats_left <= '0;
      beat_buf   <= '0;
    end else begin
      if (ar_valid && bus.m_mem_axi_arready) ar_valid <= 1'b0;
      if (accept) begin
        error <= 1'b0;
        x_res <= conf_x_resolution;
        y_res <= conf_y_resolution;
        x_pos <= '0;
        y_pos <= '0;
        sub   <= '0;
        if (!zero) begin
          busy       <= 1'b1;
          ar_valid   <= 1'b1;
          ar_addr    <= conf_addr;
          ar_id      <= ar_id + ID_WIDTH'(1);
          beats_left <= beats - TW'(1);
        end
      end
      if (r_hs) begin
        beat_buf <= bus.m_mem_axi_rdata;
        f_valid  <= 1'b1;
        if (bus.m_mem_axi_rresp != 2'b00) error <= 1'b1;
        if (beats_left != '0) begin
          ar_valid   <= 1'b1;
          ar_addr    <= ar_addr + ADDR_WIDTH'(STRB_WIDTH);
          ar_id      <= ar_id + ID_WIDTH'(1);
          beats_left <= beats_left - TW'(1);
        end
      end
      if (f_hs) begin
        beat_buf <= beat_buf >> PIXEL_WIDTH;
        x_pos    <= x_last ? '0 : x_pos + X_BIT_WIDTH'(1);
        y_pos    <= x_last ? y_pos + Y_BIT_WIDTH'(1) : y_pos;
        if (last_pix) begin
          busy    <= 1'b0;
          f_valid <= 1'b0;
        end else if (sub == SW'(PPB - 1)) begin
          f_valid <= 1'b0;
          sub     <= '0;
        end else begin
          sub <= sub + SW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_framebuffer_reader.sv
// tb_framebuffer_reader: randomized scoreboard bench with a behavioural memory and frame model.
module tb_framebuffer_reader;
  localparam int DW = 32, AW = 32, IW = 8, XW = 11, YW = 11, PW = 16, PPB = DW / PW;
  typedef struct packed {logic [PW-1:0] d; logic [XW-1:0] x; logic [YW-1:0] y; logic last;} pix_t;
  typedef struct packed {logic [AW-1:0] a; logic [IW-1:0] id;} ar_t;
  logic aclk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic busy, error;
  logic [AW-1:0] conf_addr = '0;
  logic [XW-1:0] conf_x = '0;
  logic [YW-1:0] conf_y = '0;
  int checks = 0, failures = 0;
  ar_t exp_ar[$];
  pix_t exp_pix[$];
  logic [IW-1:0] exp_id = '0;
  int tmode = 0, admode = 0, emode = 0, err_beat = 0, beat_no = 0, r_beats = 0;
  bit flush = 0, err_seen = 0;
  framebuffer_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .X_BIT_WIDTH(XW),
    .Y_BIT_WIDTH(YW), .PIXEL_WIDTH(PW)) bus ();
  framebuffer_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .X_BIT_WIDTH(XW),
    .Y_BIT_WIDTH(YW), .PIXEL_WIDTH(PW)) dut (
    .aclk(aclk), .resetn(resetn), .start(start), .busy(busy), .error(error),
    .conf_addr(conf_addr), .conf_x_resolution(conf_x), .conf_y_resolution(conf_y), .bus(bus));
  always #5 aclk = ~aclk;
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic fail_unexpected(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=nothing", name, act);
  endtask
  task automatic push_frame(input logic [AW-1:0] a, input int x, input int y);
    int total, beats;
    logic [DW-1:0] w;
    pix_t p;
    ar_t r;
    total = x * y;
    beats = (total + PPB - 1) / PPB;
    for (int b = 0; b < beats; b++) begin
      exp_id = exp_id + 8'd1;
      r.a = a + AW'(b * (DW / 8));
      r.id = exp_id;
      exp_ar.push_back(r);
    end
    for (int i = 0; i < total; i++) begin
      w = mem_word(a + AW'((i / PPB) * (DW / 8)));
      p.d = PW'(w >> (PW * (i % PPB)));
      p.x = XW'(i % x);
      p.y = YW'(i / x);
      p.last = (i == total - 1);
      exp_pix.push_back(p);
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_arvalid"}, bus.m_mem_axi_arvalid, 0);
    chk({tag, "_arid"}, bus.m_mem_axi_arid, 0);
    chk({tag, "_rready"}, bus.m_mem_axi_rready, 0);
    chk({tag, "_tvalid"}, bus.m_frag_tvalid, 0);
    chk({tag, "_tlast"}, bus.m_frag_tlast, 0);
    chk({tag, "_txpos"}, bus.m_frag_txpos, 0);
    chk({tag, "_typos"}, bus.m_frag_typos, 0);
  endtask
  task automatic run_frame(input logic [AW-1:0] a, input int x, input int y, input bit mid);
    int cyc, budget;
    budget = 200 + 40 * x * y;
    @(posedge aclk); #2;
    conf_addr = a;
    conf_x = XW'(x);
    conf_y = YW'(y);
    start = 1'b1;
    err_seen = 0;
    beat_no = 0;
    push_frame(a, x, y);
    @(posedge aclk); #2;
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_error_clr", error, 0);
    chk("accept_arvalid", bus.m_mem_axi_arvalid, 1);
    cyc = 0;
    while (busy && cyc < budget) begin
      @(posedge aclk); #2;
      cyc++;
      start = mid && (cyc == 5 || (bus.m_frag_tvalid && bus.m_frag_tlast && bus.m_frag_tready));
      if (start) begin
        conf_addr = 32'hDEAD0000;
        conf_x = 11'd2;
        conf_y = 11'd2;
      end
    end
    start = 1'b0;
    if (cyc >= budget) fail_unexpected("frame_timeout", 64'(cyc));
    repeat (2) @(posedge aclk);
    #2;
    chk("end_busy", busy, 0);
    chk("end_tvalid", bus.m_frag_tvalid, 0);
    chk("end_ar_left", 64'(exp_ar.size()), 0);
    chk("end_pix_left", 64'(exp_pix.size()), 0);
    chk("end_error", error, err_seen);
  endtask
  initial begin : slave
    bit ar_hs, r_hs, pending;
    logic [AW-1:0] ar_a, p_addr;
    int ar_wait, rnd_delay, r_dly;
    ar_wait = 0; rnd_delay = 0; r_dly = 0; pending = 0;
    bus.m_mem_axi_arready = 1'b0;
    bus.m_mem_axi_rvalid = 1'b0;
    bus.m_mem_axi_rdata = '0;
    bus.m_mem_axi_rresp = 2'b00;
    bus.m_mem_axi_rid = '0;
    bus.m_mem_axi_rlast = 1'b0;
    forever begin
      @(negedge aclk);
      ar_hs = bus.m_mem_axi_arvalid && bus.m_mem_axi_arready;
      r_hs = bus.m_mem_axi_rvalid && bus.m_mem_axi_rready;
      ar_a = bus.m_mem_axi_araddr;
      if (ar_hs || !bus.m_mem_axi_arvalid) ar_wait = 0;
      else ar_wait++;
      @(posedge aclk); #1;
      if (flush) begin
        pending = 0;
        ar_wait = 0;
        bus.m_mem_axi_rvalid = 1'b0;
        flush = 0;
      end else begin
        if (r_hs) bus.m_mem_axi_rvalid = 1'b0;
        if (ar_hs) begin
          pending = 1;
          p_addr = ar_a;
          r_dly = $urandom_range(0, 2);
          rnd_delay = $urandom_range(0, 3);
        end
        if (pending && !bus.m_mem_axi_rvalid) begin
          if (r_dly == 0) begin
            bus.m_mem_axi_rvalid = 1'b1;
            bus.m_mem_axi_rdata = mem_word(p_addr);
            bus.m_mem_axi_rresp = (emode == 1 && beat_no == err_beat) ||
                                  (emode == 2 && $urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            bus.m_mem_axi_rid = IW'($urandom);
            bus.m_mem_axi_rlast = 1'b1;
            pending = 0;
            beat_no++;
          end else r_dly--;
        end
      end
      bus.m_mem_axi_arready = ar_wait >= (admode == 0 ? 0 : admode == 1 ? 3 : rnd_delay);
    end
  end
  initial begin : sink
    bus.m_frag_tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      bus.m_frag_tready = tmode == 0 ? 1'b1 : tmode == 1 ? !bus.m_frag_tready : ($urandom_range(0, 2) != 0);
    end
  end
  initial begin : monitor
    bit ar_st, f_st, err_next;
    ar_t ar_prev, ca;
    pix_t f_prev, cur;
    ar_st = 0; f_st = 0; err_next = 0;
    forever begin
      @(negedge aclk);
      cur.d = bus.m_frag_tdata;
      cur.x = bus.m_frag_txpos;
      cur.y = bus.m_frag_typos;
      cur.last = bus.m_frag_tlast;
      ca.a = bus.m_mem_axi_araddr;
      ca.id = bus.m_mem_axi_arid;
      if (!resetn) begin
        ar_st = 0; f_st = 0; err_next = 0;
      end else begin
        if (err_next) chk("error_set", error, 1);
        err_next = 0;
        if (ar_st) chk("ar_hold", {bus.m_mem_axi_arvalid, ca}, {1'b1, ar_prev});
        if (f_st) chk("frag_hold", {bus.m_frag_tvalid, cur}, {1'b1, f_prev});
        if (bus.m_mem_axi_arvalid && bus.m_mem_axi_arready) begin
          chk("ar_const", {bus.m_mem_axi_arlen, bus.m_mem_axi_arsize, bus.m_mem_axi_arburst,
              bus.m_mem_axi_arlock, bus.m_mem_axi_arcache, bus.m_mem_axi_arprot},
              {8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0});
          if (exp_ar.size() == 0) fail_unexpected("ar_unexpected", 64'(ca));
          else chk("ar_addr_id", ca, exp_ar.pop_front());
        end
        if (bus.m_frag_tvalid && bus.m_frag_tready) begin
          if (exp_pix.size() == 0) fail_unexpected("pix_unexpected", 64'(cur));
          else chk("pixel", cur, exp_pix.pop_front());
        end
        if (bus.m_mem_axi_rvalid && !busy) chk("rready_idle", bus.m_mem_axi_rready, 0);
        if (bus.m_mem_axi_rvalid && bus.m_mem_axi_rready) begin
          r_beats++;
          if (bus.m_mem_axi_rresp != 2'b00) begin
            err_seen = 1;
            err_next = 1;
          end
        end
        ar_st = bus.m_mem_axi_arvalid && !bus.m_mem_axi_arready;
        ar_prev = ca;
        f_st = bus.m_frag_tvalid && !bus.m_frag_tready;
        f_prev = cur;
      end
    end
  end
  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin : main
    int cyc, rb, x, y;
    repeat (3) @(posedge aclk);
    #2;
    check_reset("init");
    resetn = 1'b1;
    run_frame(32'h1000, 4, 2, 0);
    run_frame(32'h1100, 3, 1, 0);
    tmode = 1; admode = 1;
    run_frame(32'h1000, 4, 2, 0);
    tmode = 0; admode = 0; emode = 1; err_beat = 1;
    run_frame(32'h1200, 4, 1, 0);
    emode = 0;
    run_frame(32'h1300, 2, 2, 0);
    tmode = 2; admode = 2;
    run_frame(32'h1400, 5, 3, 1);
    @(posedge aclk); #2;
    conf_addr = 32'h5000; conf_x = 11'd0; conf_y = 11'd5; start = 1'b1;
    @(posedge aclk); #2;
    start = 1'b0;
    repeat (4) begin
      chk("zero_busy", busy, 0);
      chk("zero_arvalid", bus.m_mem_axi_arvalid, 0);
      @(posedge aclk); #2;
    end
    tmode = 0; admode = 0;
    conf_addr = 32'h2000; conf_x = 11'd8; conf_y = 11'd4; start = 1'b1;
    push_frame(32'h2000, 8, 4);
    rb = r_beats;
    @(posedge aclk); #2;
    start = 1'b0;
    cyc = 0;
    while (r_beats == rb && cyc < 100) begin
      @(posedge aclk); #2;
      cyc++;
    end
    chk("beat0_wait", cyc < 100, 1);
    resetn = 1'b0;
    @(posedge aclk); #2;
    check_reset("midreset");
    resetn = 1'b1;
    exp_ar.delete();
    exp_pix.delete();
    exp_id = '0;
    repeat (6) @(posedge aclk);
    #2;
    flush = 1;
    repeat (2) @(posedge aclk);
    run_frame(32'h3000, 4, 2, 0);
    tmode = 2; admode = 2; emode = 2;
    for (int i = 0; i < 10; i++) begin
      x = $urandom_range(1, 9);
      y = $urandom_range(1, 6);
      run_frame({16'h0, 14'($urandom), 2'b00}, x, y, $urandom_range(0, 1) == 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
